ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-port arbiter/sequencer for the single-port latch-based RAM.
//  Shares the RAM between port A (fetch) and port B (data) with req/gnt/done handshakes.
//  Generates latch-safe strobes: address/data setup, enable pulse, hold.
//  Sits between the CPU control path and the RAM array.
// PARAMETERS
//  AW        4  RAM address width
//  DW        8  RAM data width
//  WR_PULSE  1  cycles ram_webar is held low per write (>=1)
//  RD_WAIT   1  cycles from chip-select to ram_dout capture (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rstbar     in   1   asynchronous active-low reset
//  a_req      in   1   port A request; hold until a_gnt
//  a_we       in   1   port A: 1=write, 0=read; stable while a_req
//  a_addr     in   AW  port A address
//  a_wdata    in   DW  port A write data
//  a_gnt      out  1   one-cycle pulse: port A request accepted
//  a_done     out  1   one-cycle pulse: port A access complete
//  a_rdata    out  DW  port A read data; valid at a_done, held until next A read
//  b_*        --   --  identical set for port B
//  ram_addr   out  AW  RAM address
//  ram_din    out  DW  RAM write data
//  ram_dout   in   DW  RAM read data
//  ram_csbar  out  1   RAM chip select, active low
//  ram_webar  out  1   RAM write enable, active low
// BEHAVIOUR
//  - All outputs registered. Reset (async, rstbar=0) forces:
//    state=IDLE, gnt/done=0, rdata=0, ram_addr=0, ram_din=0, ram_csbar=1, ram_webar=1.
//    The last-served pointer resets to B, so A wins the first tie.
//  - FSM: IDLE -> SETUP -> (STROBE x WR_PULSE -> HOLD | RWAIT x RD_WAIT) -> DONE -> IDLE.
//  - IDLE: if any req is high at the edge, pick a winner and capture its we/addr/wdata into internal regs.
//    Pulse the winner's gnt and enter SETUP. ram_addr/ram_din come only from the captured regs.
//  - SETUP (1 cycle): csbar=0, webar=1, addr/din stable.
//  - STROBE: webar=0 for exactly WR_PULSE cycles. HOLD (1 cycle): webar=1, csbar=0, addr/din unchanged.
//  - RWAIT: csbar=0 for RD_WAIT cycles. On the last cycle, ram_dout is latched into the winner's rdata.
//  - DONE (1 cycle): winner's done=1, csbar=1, pointer <= winner.
//  - Latency from gnt rise: write done = WR_PULSE+2 cycles; read done = RD_WAIT+1 cycles.
//  - ram_addr/ram_din never change while csbar=0. webar never falls in the same cycle addr changes.
//  - Round robin: if both req high in IDLE, the port not last served wins. The loser keeps req high and is served next.
//  - A req still high at DONE is a new request; minimum one IDLE cycle between accesses.
//  - req dropped before gnt: withdrawn, no access. Dropped after gnt: ignored, access completes.
//  - Async reset mid-write: webar/csbar return high immediately. Addressed RAM word is undefined; others unaffected.
//  - Only one gnt and one done high in any cycle. The non-winning rdata is never modified.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN defined: fixed priority, B always beats A when both request (A can starve).
//  The pointer register is removed.
//  Not defined: round robin as above.
// TESTING
//  1. Reset held, all req=0 -> csbar=1, webar=1, gnt/done=0, rdata=0; release: stays IDLE.
//  2. A write addr=3 data=8'h5A (WR_PULSE=1):
//     -> a_gnt, webar low 1 cycle with ram_addr=3, ram_din=5A; a_done 3 cycles after a_gnt.
//  3. B read addr=3 after step 2 (RD_WAIT=1) -> b_done 2 cycles after b_gnt, b_rdata=8'h5A, a_rdata unchanged.
//  4. a_req and b_req held high together, reads -> grants alternate A,B,A,B; never two gnt in one cycle.
//     With RAM_ARB_FIXED_PRIO_EN: B,B,B.
//  5. rstbar pulsed low during STROBE -> webar=1, csbar=1 same time step; after release, IDLE and no done pulse.
//  6. a_req dropped after a_gnt (write 7<-8'hC3) -> a_done still pulses; a read of addr 7 returns C3.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle joining the two requesting ports (A = fetch, B = data),
// the arbiter and the single-port latch RAM.
interface ram_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          a_req, a_we, a_gnt, a_done;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;

  logic          b_req, b_we, b_gnt, b_done;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_csbar, ram_webar;

  // arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_dout,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output ram_addr, ram_din, ram_csbar, ram_webar
  );

  // requesters plus RAM array side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_dout,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  ram_addr, ram_din, ram_csbar, ram_webar
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a single-port latch RAM with latch-safe strobes.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (B beats A); default is round robin.
module ram_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int WR_PULSE = 1,
  parameter int RD_WAIT  = 1
) (
  input  logic         clk,
  input  logic         rstbar,
  ram_arbiter_if.slave bus
);

  localparam int MAXW = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RWAIT  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;     // 1: port B owns the current access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          a_done_q, a_done_d, b_done_q, b_done_d;
  logic          csbar_q, csbar_d, webar_q, webar_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          win_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign win_b = bus.b_req;
`else
  logic last_q, last_d;  // 1: B was served last, so A wins a tie

  assign win_b  = bus.b_req & (~bus.a_req | ~last_q);
  assign last_d = (state_q == DONE) ? sel_q : last_q;

  always_ff @(posedge clk or negedge rstbar) begin
    if (!rstbar) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          sel_d   = win_b;
          we_d    = win_b ? bus.b_we    : bus.a_we;
          addr_d  = win_b ? bus.b_addr  : bus.a_addr;
          wdata_d = win_b ? bus.b_wdata : bus.a_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = we_q ? STROBE : RWAIT;
      end
      STROBE: begin
        if (cnt_q == WR_LAST) state_d = HOLD;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      HOLD: state_d = DONE;
      RWAIT: begin
        if (cnt_q == RD_LAST) begin
          state_d = DONE;
          if (sel_q) b_rdata_d = bus.ram_dout;
          else       a_rdata_d = bus.ram_dout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so each pin is glitch-free
    // and aligned with the state it belongs to.
    a_gnt_d  = (state_q == IDLE) && (state_d == SETUP) && !sel_d;
    b_gnt_d  = (state_q == IDLE) && (state_d == SETUP) &&  sel_d;
    a_done_d = (state_d == DONE) && !sel_d;
    b_done_d = (state_d == DONE) &&  sel_d;
    csbar_d  = !(state_d inside {SETUP, STROBE, HOLD, RWAIT});
    webar_d  = (state_d != STROBE);
  end

  always_ff @(posedge clk or negedge rstbar) begin
    if (!rstbar) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      csbar_q   <= 1'b1;
      webar_q   <= 1'b1;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      csbar_q   <= csbar_d;
      webar_q   <= webar_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // The RAM address/data pins come straight from the capture registers,
  // which only load on a grant, so they stay still for the whole access.
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = wdata_q;
  assign bus.ram_csbar = csbar_q;
  assign bus.ram_webar = webar_q;
  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_done    = a_done_q;
  assign bus.b_done    = b_done_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;

endmodule
